// File: rtl/fft_stage_seq.sv
// Address/enable sequencer for the in-place radix-2 FFT: one 2^FFT_STG sweep per stage,
// a fixed drain gap between stages, plus stage/bank/first/last/busy/done status.
module fft_stage_seq #(
  parameter int FFT_STG   = 7,
  parameter int ADDR_W    = 7,
  parameter int DRAIN_CYC = 4
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic              ihold,
  output logic              oen,
  output logic [ADDR_W-1:0] oaddr,
  output logic [3:0]        ostage,
  output logic              obank,
  output logic              ofirst,
  output logic              olast,
  output logic              obusy,
  output logic              odone
);

  localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [FFT_STG-1:0] CNT_MAX  = '1;
  localparam logic [3:0]         STG_LAST = 4'(FFT_STG - 1);
  localparam logic [DW-1:0]      DRAIN_LD = DW'(DRAIN_CYC);
  localparam logic [DW-1:0]      DRAIN_ONE = DW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic [FFT_STG-1:0]  cnt_q;
  logic [3:0]          stage_q;
  logic                bank_q;
  logic [DW-1:0]       drain_q;
  logic                oen_q, ofirst_q, olast_q, obusy_q, odone_q, obank_q;
  logic [ADDR_W-1:0]   oaddr_q;
  logic [3:0]          ostage_q;

  logic                last_stg;
  logic [3:0]          stage_d;
  logic [FFT_STG-1:0]  cnt_d;

  assign last_stg = (stage_q == STG_LAST);
  assign stage_d  = stage_q + 4'd1;
  assign cnt_d    = cnt_q + 1'b1;

  // Single-process FSM; every output is a register.
  // Handshake: oen is a pure valid (no ready); a held cycle issues nothing and keeps oaddr.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      stage_q  <= '0;
      bank_q   <= 1'b0;
      drain_q  <= '0;
      oen_q    <= 1'b0;
      oaddr_q  <= '0;
      ostage_q <= '0;
      obank_q  <= 1'b0;
      ofirst_q <= 1'b0;
      olast_q  <= 1'b0;
      obusy_q  <= 1'b0;
      odone_q  <= 1'b0;
    end else begin
      oen_q    <= 1'b0;
      ofirst_q <= 1'b0;
      olast_q  <= 1'b0;
      odone_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (istart) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            stage_q  <= '0;
            bank_q   <= 1'b0;
            ostage_q <= '0;
            obank_q  <= 1'b0;
            obusy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!ihold) begin
            oen_q    <= 1'b1;
            oaddr_q  <= ADDR_W'(cnt_q);
            ostage_q <= stage_q;
            obank_q  <= bank_q;
            ofirst_q <= (cnt_q == '0);
            olast_q  <= (cnt_q == CNT_MAX);
            cnt_q    <= cnt_d;
            if (cnt_q == CNT_MAX) begin
              if (DRAIN_CYC == 0) begin
                // No drain gap: the next stage's address 0 follows immediately.
                if (last_stg) begin
                  state_q <= S_DONE;
                end else begin
                  stage_q <= stage_d;
                  bank_q  <= ~bank_q;
                end
              end else begin
                state_q <= S_DRAIN;
                drain_q <= DRAIN_LD;
              end
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_ONE) begin
            if (last_stg) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
              stage_q <= stage_d;
              bank_q  <= ~bank_q;
            end
          end else begin
            drain_q <= drain_q - DRAIN_ONE;
          end
        end
        S_DONE: begin
          odone_q <= 1'b1;
          obusy_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oen    = oen_q;
  assign oaddr  = oaddr_q;
  assign ostage = ostage_q;
  assign obank  = obank_q;
  assign ofirst = ofirst_q;
  assign olast  = olast_q;
  assign obusy  = obusy_q;
  assign odone  = odone_q;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed bench for fft_stage_seq: default config plus two 8-point, 3-stage configs
// (no drain gap, and a 2-cycle drain gap) exercising hold, restart and reset cases.
module tb_fft_stage_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Instance a: default parameters
  logic       a_start, a_hold, a_en, a_bank, a_first, a_last, a_busy, a_done;
  logic [6:0] a_addr;
  logic [3:0] a_stage;
  // Instance b: FFT_STG=3, DRAIN_CYC=0, ADDR_W=4
  logic       b_start, b_hold, b_en, b_bank, b_first, b_last, b_busy, b_done;
  logic [3:0] b_addr;
  logic [3:0] b_stage;
  // Instance c: FFT_STG=3, DRAIN_CYC=2, ADDR_W=4
  logic       c_start, c_hold, c_en, c_bank, c_first, c_last, c_busy, c_done;
  logic [3:0] c_addr;
  logic [3:0] c_stage;

  fft_stage_seq u_a (
    .iclk(clk), .irst(rst), .istart(a_start), .ihold(a_hold),
    .oen(a_en), .oaddr(a_addr), .ostage(a_stage), .obank(a_bank),
    .ofirst(a_first), .olast(a_last), .obusy(a_busy), .odone(a_done)
  );

  fft_stage_seq #(.FFT_STG(3), .ADDR_W(4), .DRAIN_CYC(0)) u_b (
    .iclk(clk), .irst(rst), .istart(b_start), .ihold(b_hold),
    .oen(b_en), .oaddr(b_addr), .ostage(b_stage), .obank(b_bank),
    .ofirst(b_first), .olast(b_last), .obusy(b_busy), .odone(b_done)
  );

  fft_stage_seq #(.FFT_STG(3), .ADDR_W(4), .DRAIN_CYC(2)) u_c (
    .iclk(clk), .irst(rst), .istart(c_start), .ihold(c_hold),
    .oen(c_en), .oaddr(c_addr), .ostage(c_stage), .obank(c_bank),
    .ofirst(c_first), .olast(c_last), .obusy(c_busy), .odone(c_done)
  );

  task automatic test_reset();
    logic [17:0] va;
    logic [14:0] vb, vc;
    rst = 1'b1;
    a_start = 1'b0; a_hold = 1'b0;
    b_start = 1'b0; b_hold = 1'b0;
    c_start = 1'b0; c_hold = 1'b0;
    @(negedge clk);
    va = {a_en, a_addr, a_stage, a_bank, a_first, a_last, a_busy, a_done};
    vb = {b_en, b_addr, b_stage, b_bank, b_first, b_last, b_busy, b_done};
    vc = {c_en, c_addr, c_stage, c_bank, c_first, c_last, c_busy, c_done};
    vec_cnt++; if (va !== 18'h0) begin err_cnt++; $display("FAIL reset_a got=%h exp=0", va); end
    vec_cnt++; if (vb !== 15'h0) begin err_cnt++; $display("FAIL reset_b got=%h exp=0", vb); end
    vec_cnt++; if (vc !== 15'h0) begin err_cnt++; $display("FAIL reset_c got=%h exp=0", vc); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    int s, o, n_en;
    logic en;
    logic [4:0] got_v, exp_v;
    logic [11:0] got_d, exp_d;
    logic [6:0] ea;
    n_en = 0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    got_v = {a_en, a_first, a_last, a_busy, a_done};
    vec_cnt++; if (got_v !== 5'b00010) begin err_cnt++; $display("FAIL full_c0 got=%b exp=00010", got_v); end
    for (int c = 1; c <= 930; c++) begin
      @(negedge clk);
      s  = (c - 1) / 132;
      o  = (c - 1) % 132;
      en = (s < 7) && (o < 128);
      exp_v = {en, en && (o == 0), en && (o == 127), c < 925, c == 925};
      got_v = {a_en, a_first, a_last, a_busy, a_done};
      vec_cnt++;
      if (got_v !== exp_v) begin
        err_cnt++; $display("FAIL full_ctl c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      if (en) begin
        n_en++;
        ea = o[6:0];
        exp_d = {ea, s[3:0], s[0]};
        got_d = {a_addr, a_stage, a_bank};
        vec_cnt++;
        if (got_d !== exp_d) begin
          err_cnt++; $display("FAIL full_addr c=%0d got=%h exp=%h", c, got_d, exp_d);
        end
      end
    end
    vec_cnt++; if (n_en !== 896) begin err_cnt++; $display("FAIL full_en_count got=%0d exp=896", n_en); end
    vec_cnt++;
    if ({a_stage, a_bank} !== 5'b01100) begin
      err_cnt++; $display("FAIL full_stage_hold got=%b exp=01100", {a_stage, a_bank});
    end
  endtask

  task automatic test_no_drain();
    int s, o, n_en;
    logic en;
    logic [4:0] got_v, exp_v;
    logic [8:0] got_d, exp_d;
    logic [3:0] ea;
    n_en = 0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      s  = (c - 1) / 8;
      o  = (c - 1) % 8;
      en = (c <= 24);
      exp_v = {en, en && (o == 0), en && (o == 7), c < 25, c == 25};
      got_v = {b_en, b_first, b_last, b_busy, b_done};
      vec_cnt++;
      if (got_v !== exp_v) begin
        err_cnt++; $display("FAIL nodrain_ctl c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      if (en) begin
        n_en++;
        ea = {1'b0, o[2:0]};
        exp_d = {ea, s[3:0], s[0]};
        got_d = {b_addr, b_stage, b_bank};
        vec_cnt++;
        if (got_d !== exp_d) begin
          err_cnt++; $display("FAIL nodrain_addr c=%0d got=%h exp=%h", c, got_d, exp_d);
        end
      end
    end
    vec_cnt++; if (n_en !== 24) begin err_cnt++; $display("FAIL nodrain_en_count got=%0d exp=24", n_en); end
  endtask

  task automatic test_hold();
    int e, s, o;
    logic en;
    logic [4:0] got_v, exp_v;
    logic [8:0] got_d, exp_d;
    logic [3:0] ea;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      // Holds at edges 3..5 stall RUN; holds at edges 12..13 land in DRAIN and are ignored.
      if (c <= 2) e = c;
      else if (c <= 5) e = -1;
      else e = c - 3;
      if (e < 0) begin
        en = 1'b0; s = 0; o = 0;
      end else begin
        s  = (e - 1) / 10;
        o  = (e - 1) % 10;
        en = (s < 3) && (o < 8);
      end
      exp_v = {en, en && (o == 0), en && (o == 7), c < 34, c == 34};
      got_v = {c_en, c_first, c_last, c_busy, c_done};
      vec_cnt++;
      if (got_v !== exp_v) begin
        err_cnt++; $display("FAIL hold_ctl c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      if (en || e < 0) begin
        ea = (e < 0) ? 4'd1 : {1'b0, o[2:0]};
        exp_d = {ea, s[3:0], s[0]};
        got_d = {c_addr, c_stage, c_bank};
        vec_cnt++;
        if (got_d !== exp_d) begin
          err_cnt++; $display("FAIL hold_addr c=%0d got=%h exp=%h", c, got_d, exp_d);
        end
      end
      c_hold = ((c + 1 >= 3) && (c + 1 <= 5)) || ((c + 1 >= 12) && (c + 1 <= 13));
    end
    c_hold = 1'b0;
  endtask

  task automatic test_continuous_hold();
    int done_at;
    logic [9:0] got_v;
    done_at = -1;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c >= 6 && c <= 25) begin
        got_v = {c_en, c_addr, c_stage, c_busy};
        vec_cnt++;
        if (got_v !== 10'b0_0100_0000_1) begin
          err_cnt++; $display("FAIL cont_hold c=%0d got=%b exp=0010000001", c, got_v);
        end
      end
      if (c == 26) begin
        got_v = {c_en, c_addr, c_stage, c_busy};
        vec_cnt++;
        if (got_v !== 10'b1_0101_0000_1) begin
          err_cnt++; $display("FAIL cont_resume got=%b exp=1010100001", got_v);
        end
      end
      if (c_done && done_at < 0) done_at = c;
      c_hold = (c >= 5) && (c <= 24);
    end
    c_hold = 1'b0;
    vec_cnt++; if (done_at !== 51) begin err_cnt++; $display("FAIL cont_done_at got=%0d exp=51", done_at); end
  endtask

  task automatic test_start_ignored();
    int n_done, first_done, last_done;
    logic [6:0] got_v;
    n_done = 0; first_done = -1; last_done = -1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      if (b_done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        last_done = c;
      end
      if (c == 25) begin
        vec_cnt++;
        if (b_stage !== 4'd2) begin err_cnt++; $display("FAIL restart_prev_stage got=%0d exp=2", b_stage); end
      end
      if (c == 26) begin
        got_v = {b_busy, b_stage, b_bank, b_en};
        vec_cnt++;
        if (got_v !== 7'b1_0000_0_0) begin err_cnt++; $display("FAIL restart_c26 got=%b exp=1000000", got_v); end
      end
      if (c == 27) begin
        got_v = {b_en, b_addr[1:0], b_stage[2:0], b_first};
        vec_cnt++;
        if (got_v !== 7'b1_00_000_1) begin err_cnt++; $display("FAIL restart_c27 got=%b exp=1000001", got_v); end
      end
      // Pulses at edge 11 (mid-frame) and edge 25 (DONE) are ignored; edge 26 restarts.
      b_start = (c + 1 == 11) || (c + 1 == 25) || (c + 1 == 26);
    end
    b_start = 1'b0;
    vec_cnt++; if (n_done !== 2) begin err_cnt++; $display("FAIL restart_done_count got=%0d exp=2", n_done); end
    vec_cnt++; if (first_done !== 25) begin err_cnt++; $display("FAIL restart_done1 got=%0d exp=25", first_done); end
    vec_cnt++; if (last_done !== 51) begin err_cnt++; $display("FAIL restart_done2 got=%0d exp=51", last_done); end
  endtask

  task automatic test_reset_mid_frame();
    int n_en, n_done, done_at;
    logic [14:0] vc;
    logic [2:0] got_v;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    repeat (29) @(negedge clk);
    got_v = {c_en, c_stage[1:0]};
    vec_cnt++;
    if (got_v !== 3'b010 || c_busy !== 1'b1) begin
      err_cnt++; $display("FAIL rst_pre_drain got=%b busy=%b exp=010 busy=1", got_v, c_busy);
    end
    #2 rst = 1'b1;
    #1;
    vc = {c_en, c_addr, c_stage, c_bank, c_first, c_last, c_busy, c_done};
    vec_cnt++; if (vc !== 15'h0) begin err_cnt++; $display("FAIL rst_async got=%h exp=0", vc); end
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c_done || c_busy) n_done++;
    end
    vec_cnt++; if (n_done !== 0) begin err_cnt++; $display("FAIL rst_no_done got=%0d exp=0", n_done); end
    n_en = 0; done_at = -1;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1) begin
        got_v = {c_en, c_stage[0], c_bank};
        vec_cnt++;
        if (got_v !== 3'b100 || c_addr !== 4'd0 || c_stage !== 4'd0) begin
          err_cnt++; $display("FAIL rst_refirst got=%b addr=%0d stage=%0d exp=100 addr=0 stage=0", got_v, c_addr, c_stage);
        end
      end
      if (c_en) n_en++;
      if (c_done && done_at < 0) done_at = c;
    end
    vec_cnt++; if (n_en !== 24) begin err_cnt++; $display("FAIL rst_re_en_count got=%0d exp=24", n_en); end
    vec_cnt++; if (done_at !== 31) begin err_cnt++; $display("FAIL rst_re_done_at got=%0d exp=31", done_at); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_no_drain();
    test_hold();
    test_continuous_hold();
    test_start_ignored();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
